dbus_sram_responder: RTL and testbench

// - Responder (slave) end of the core's data bus: accepts dbus_req_t from the memory stage, returns dbus_resp_t.
// - Backs requests with a DEPTH x 64-bit SRAM and programmable response latency.
// - Exercises the core's stalldata path: data_ok is withheld for LATENCY cycles.
// - Used as the data-side memory model in core-level simulation and FPGA bring-up.

---
 rtl/dbus_sram_responder_if.sv | 27 ++
 rtl/dbus_sram_responder.sv | 167 ++++++++++++++++
 tb/tb_dbus_sram_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response types and the bus bundle between the memory stage and its responder.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

interface dbus_sram_responder_if;
    import dbus_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       bus_err;

    modport master (output dreq, input dresp, input bus_err);
    modport slave  (input dreq, output dresp, output bus_err);
endinterface

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: DEPTH x 64-bit store, one transaction at a time, data_ok after LATENCY cycles.
// Optional DBUS_RESP_RANDLAT_EN adds 0..3 LFSR-chosen extra wait cycles per transaction.
module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dbus_sram_responder_if.slave bus
);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            hit_q, hit_d;
    logic            wr_q, wr_d;
    logic [7:0]      strb_q, strb_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            data_ok_q, data_ok_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [63:0]     mem [DEPTH];

    logic [63:0]     off;
    logic            req_hit;
    logic [IDXW-1:0] req_idx;
    logic            accept;
    logic [4:0]      lat_m1;
    logic [3:0]      cnt_init;
    logic [IDXW-1:0] rsp_idx;
    logic            rsp_hit;
    logic            rsp_wr;
    logic            rsp_go;
    logic            unused_size;

    // The SRAM is word-granular; lane alignment by size is the core's job.
    assign unused_size = ^bus.dreq.size;

    assign off     = bus.dreq.addr - BASE;
    assign req_hit = (bus.dreq.addr >= BASE) && (off < SPAN);
    assign req_idx = off[IDXW+2:3];
    assign accept  = (state_q == IDLE) && bus.dreq.valid;

`ifdef DBUS_RESP_RANDLAT_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end

    assign lat_m1 = 5'(LATENCY - 1) + {3'b000, lfsr_q[1:0]};
`else
    assign lat_m1 = 5'(LATENCY - 1);
`endif

    assign cnt_init = (lat_m1 > 5'd15) ? 4'd15 : lat_m1[3:0];

    // With LATENCY==1 the response is prepared in the accept cycle, before the request is latched.
    assign rsp_idx = (state_q == IDLE) ? req_idx : idx_q;
    assign rsp_hit = (state_q == IDLE) ? req_hit : hit_q;
    assign rsp_wr  = (state_q == IDLE) ? (bus.dreq.strobe != 8'h00) : wr_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        wr_d      = wr_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        data_ok_d = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        rsp_go    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = req_idx;
                    hit_d   = req_hit;
                    wr_d    = (bus.dreq.strobe != 8'h00);
                    strb_d  = bus.dreq.strobe;
                    wdata_d = bus.dreq.data;
                    cnt_d   = cnt_init;
                    if (cnt_init == 4'd0) begin
                        state_d = RESP;
                        rsp_go  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                    rsp_go  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Reads sample the array on entry to RESP; transactions are serialized so no write can intervene.
        if (rsp_go) begin
            data_ok_d = 1'b1;
            err_d     = !rsp_hit;
            rdata_d   = (rsp_hit && !rsp_wr) ? mem[rsp_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            wr_q      <= 1'b0;
            strb_q    <= 8'h00;
            wdata_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            wr_q      <= wr_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Contents survive reset; a reset before RESP leaves state_q out of RESP, dropping the write.
    always_ff @(posedge clk) begin
        if (state_q == RESP && wr_q && hit_q) begin
            for (int i = 0; i < 8; i++) begin
                if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.dresp = '{addr_ok: accept && reset, data_ok: data_ok_q, data: rdata_q};
    assign bus.bus_err = err_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: transaction-level timing/memory model checked every cycle plus literal pins.
module tb_dbus_sram_responder;
    import dbus_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned LAT0  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dbus_sram_responder_if b0 ();
    dbus_sram_responder_if b1 ();

    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(rst_n), .bus(b0)
    );
    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .bus(b1)
    );

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;

    // Transaction-level model of u_dut0
    bit               m_busy = 1'b0;
    int               m_due, m_acc;
    bit               m_wr, m_hit;
    longint unsigned  m_idx;
    logic [7:0]       m_strb;
    logic [63:0]      m_wd;
    logic [7:0]       m_lfsr = 8'hA5;
    logic [63:0]      mm [longint unsigned];

    bit               dok0;
    logic [63:0]      last_data;
    logic             last_err;
    int               last_lat;

    bit               rec1 = 1'b0;
    int               rcyc = 0;
    logic [15:0]      aok1 = '0;
    logic [15:0]      dok1 = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s at cycle %0d: got %b, want %b", nm, cyc, act, exp);
        end
    endtask

    task automatic check();
        logic [63:0] off, ed, tmp;
        bit eaok, edok, known;
        cyc++;
        dok0 = b0.dresp.data_ok;
        if (rec1 && rcyc < 16) begin
            aok1[rcyc] = b1.dresp.addr_ok;
            dok1[rcyc] = b1.dresp.data_ok;
            rcyc++;
        end
        if (!rst_n) begin
            m_busy = 1'b0;
            m_lfsr = 8'hA5;
            chk1("rst_addr_ok", b0.dresp.addr_ok, 1'b0);
            chk1("rst_data_ok", b0.dresp.data_ok, 1'b0);
            chk1("rst_bus_err", b0.bus_err, 1'b0);
            chk("rst_data", b0.dresp.data, 64'h0);
            return;
        end
        eaok = !m_busy && b0.dreq.valid;
        edok = m_busy && (cyc == m_due);
        chk1("addr_ok", b0.dresp.addr_ok, eaok);
        chk1("data_ok", b0.dresp.data_ok, edok);
        chk1("bus_err", b0.bus_err, edok && !m_hit);
        ed = 64'h0;
        known = 1'b1;
        if (edok && m_hit && !m_wr) begin
            known = mm.exists(m_idx);
            if (known) ed = mm[m_idx];
        end
        if (known) chk("data", b0.dresp.data, ed);
        if (edok) begin
            last_data = b0.dresp.data;
            last_err  = b0.bus_err;
            last_lat  = cyc - m_acc;
            m_busy    = 1'b0;
            if (m_wr && m_hit) begin
                if (mm.exists(m_idx)) begin
                    tmp = mm[m_idx];
                    for (int i = 0; i < 8; i++) if (m_strb[i]) tmp[8*i +: 8] = m_wd[8*i +: 8];
                    mm[m_idx] = tmp;
                end else if (m_strb == 8'hFF) begin
                    mm[m_idx] = m_wd;
                end
            end
        end
        if (eaok) begin
            off    = b0.dreq.addr - BASE;
            m_hit  = (b0.dreq.addr >= BASE) && (off < 64'(DEPTH) * 64'd8);
            m_idx  = off >> 3;
            m_wr   = (b0.dreq.strobe != 8'h00);
            m_strb = b0.dreq.strobe;
            m_wd   = b0.dreq.data;
            m_acc  = cyc;
            m_busy = 1'b1;
`ifdef DBUS_RESP_RANDLAT_EN
            m_due  = cyc + int'(LAT0) + int'(m_lfsr[1:0]);
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
            m_due  = cyc + int'(LAT0);
`endif
        end
    endtask

    // Sample at the falling edge, then move to just after the next rising edge to drive.
    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d, input bit hold);
        bit got;
        got = 1'b0;
        b0.dreq = '{valid: 1'b1, addr: a, size: 3'd3, strobe: s, data: d};
        step();
        for (int i = 0; i < 40 && !got; i++) begin
            if (!hold) b0.dreq.valid = 1'b0;
            step();
            got = dok0;
        end
        b0.dreq.valid = 1'b0;
        chk1("dok_timeout", got, 1'b1);
    endtask

    initial begin
        b0.dreq = '0;
        b1.dreq = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back reads on the LATENCY=1 instance with valid held high
        b1.dreq = '{valid: 1'b1, addr: BASE + 64'h40, size: 3'd3, strobe: 8'h00, data: 64'h0};
        rec1 = 1'b1;
        rcyc = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if ($countones(aok1) >= 3) b1.dreq.valid = 1'b0;
        end
        rec1 = 1'b0;
        b1.dreq.valid = 1'b0;
`ifdef DBUS_RESP_RANDLAT_EN
        chk("b2b_addr_ok_mask", 64'(aok1[13:0]), 64'h0089);
        chk("b2b_data_ok_mask", 64'(dok1[13:0]), 64'h0244);
`else
        chk("b2b_addr_ok_mask", 64'(aok1[13:0]), 64'h0015);
        chk("b2b_data_ok_mask", 64'(dok1[13:0]), 64'h002A);
`endif

        // Full write then read-back
        xact(64'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1);
`ifndef DBUS_RESP_RANDLAT_EN
        chk("wr_latency", 64'(last_lat), 64'(LAT0));
`endif
        chk1("wr_bus_err", last_err, 1'b0);
        chk("wr_data_zero", last_data, 64'h0);
        xact(64'h8000_0008, 8'h00, 64'h0, 1'b1);
        chk("rd_full", last_data, 64'h0123_4567_89AB_CDEF);

        // Partial write with valid dropped during WAIT
        xact(64'h8000_0008, 8'h0F, 64'hFFFF_FFFF_AAAA_AAAA, 1'b0);
        xact(64'h8000_000C, 8'h00, 64'h0, 1'b0);
        chk("rd_partial", last_data, 64'h0123_4567_AAAA_AAAA);

        // Out of range below BASE
        xact(64'h7FFF_FFF8, 8'h00, 64'h0, 1'b1);
        chk1("oor_rd_err", last_err, 1'b1);
        chk("oor_rd_data", last_data, 64'h0);

        // Out of range at BASE+DEPTH*8 must not alias word 0
        xact(BASE, 8'hFF, 64'h5555_6666_7777_8888, 1'b1);
        xact(BASE + 64'(DEPTH) * 64'd8, 8'hFF, 64'h9999_9999_9999_9999, 1'b1);
        chk1("oor_wr_err", last_err, 1'b1);
        xact(BASE, 8'h00, 64'h0, 1'b1);
        chk("oor_wr_unchanged", last_data, 64'h5555_6666_7777_8888);

        // Last in-range word
        xact(BASE + 64'(DEPTH) * 64'd8 - 64'd8, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0);
        xact(BASE + 64'(DEPTH) * 64'd8 - 64'd8, 8'h00, 64'h0, 1'b1);
        chk("rd_last_word", last_data, 64'hCAFE_F00D_1234_5678);
        chk1("rd_last_err", last_err, 1'b0);

        // Reset mid-WAIT drops the pending write
        xact(64'h8000_0010, 8'hFF, 64'h1111_2222_3333_4444, 1'b1);
        b0.dreq = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3, strobe: 8'hFF, data: 64'hDEAD_BEEF_0000_1111};
        step();
        rst_n = 1'b0;
        #1;
        chk1("rstw_addr_ok", b0.dresp.addr_ok, 1'b0);
        chk1("rstw_data_ok", b0.dresp.data_ok, 1'b0);
        chk1("rstw_bus_err", b0.bus_err, 1'b0);
        chk("rstw_data", b0.dresp.data, 64'h0);
        step();
        step();
        b0.dreq.valid = 1'b0;
        rst_n = 1'b1;
        step();
        xact(64'h8000_0010, 8'h00, 64'h0, 1'b1);
        chk("rstw_read_prior", last_data, 64'h1111_2222_3333_4444);

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
